// File: rtl/send_msg_param.sv
// send_msg_param: multi-field 4-phase Request/Ack message sender with Ack sync, timeout and done/error pulses
module send_msg_param #(
  parameter int DATA_W = 6,
  parameter int NUM_FIELDS = 6,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter logic [DATA_W-1:0] RST_CODE = '1,
  localparam int LEN_W = $clog2(NUM_FIELDS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         interboard_rst,
  input  logic                         ctrl_en,
  input  logic [NUM_FIELDS*DATA_W-1:0] ctrl_msg,
  input  logic [LEN_W-1:0]             ctrl_len,
  input  logic                         Ack_in,
  output logic                         send_ready,
  output logic                         msg_done,
  output logic                         timeout_err,
  output logic                         Request_out,
  output logic [DATA_W-1:0]            inter_data_out
);
  localparam int IDX_W = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;
  localparam int CNT_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, REQ, REL} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic [NUM_FIELDS*DATA_W-1:0] msg;
  logic [LEN_W-1:0] len, len_in;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic ack_s, last, expired, done_nx, err_nx;
  assign ack_s = sync[SYNC_STAGES-1];
  assign last = LEN_W'(idx) == len - LEN_W'(1);
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign len_in = (ctrl_len == '0 || ctrl_len > LEN_W'(NUM_FIELDS)) ? LEN_W'(NUM_FIELDS) : ctrl_len;
  assign send_ready = state == IDLE;
  assign Request_out = state == REQ;
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // next state and completion/abort pulse decode; interboard_rst overrides everything
  always_comb begin
    state_nx = state;
    done_nx = 1'b0;
    err_nx = 1'b0;
    if (interboard_rst) state_nx = IDLE;
    else case (state)
      IDLE: state_nx = ctrl_en ? SETUP : IDLE;
      SETUP: state_nx = REQ;
      REQ: begin
        state_nx = ack_s ? REL : expired ? IDLE : REQ;
        err_nx = !ack_s && expired;
      end
      REL: begin
        state_nx = !ack_s ? (last ? IDLE : SETUP) : expired ? IDLE : REL;
        done_nx = !ack_s && last;
        err_nx = ack_s && expired;
      end
      default: state_nx = IDLE;
    endcase
  end
  // synchroniser, message latch, field index, timeout counter and output data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      msg <= '0;
      len <= '0;
      idx <= '0;
      cnt <= '0;
      inter_data_out <= '0;
      msg_done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      sync <= SYNC_STAGES'({sync, Ack_in});
      msg_done <= done_nx;
      timeout_err <= err_nx;
      if (interboard_rst) inter_data_out <= RST_CODE;
      else if (state == IDLE && ctrl_en) begin
        msg <= ctrl_msg;
        len <= len_in;
        idx <= '0;
      end else if (state == SETUP) begin
        inter_data_out <= msg[idx*DATA_W +: DATA_W];
        cnt <= '0;
      end else if (state == REQ || state == REL) begin
        cnt <= cnt + 1'b1;
        if (state == REL && !ack_s && !last) idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_send_msg_param.sv
// tb_send_msg_param: transaction-level scoreboard plus directed checks for send_msg_param
module tb_send_msg_param;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en_a = 0, ibr_a = 0, ack_a = 0, rdy_a, done_a, err_a, rq_a;
  logic [35:0] msg_a = '0;
  logic [2:0] len_a = '0;
  logic [5:0] dat_a;
  logic en_b = 0, ibr_b = 0, ack_b = 0, rdy_b, done_b, err_b, rq_b;
  logic [31:0] msg_b = '0;
  logic [2:0] len_b = '0;
  logic [7:0] dat_b;
  int checks = 0, errors = 0;
  int dc_a = 0, dc_b = 0;
  bit stuck_b = 0;
  logic [7:0] expv[2][8];
  logic [7:0] held[2];
  int head[2], tail[2], hs[2], dones[2], errs[2];
  bit pend[2], err_ok[2], preq[2];

  send_msg_param dut_a (
    .clk(clk), .rst_n(rst_n), .interboard_rst(ibr_a), .ctrl_en(en_a), .ctrl_msg(msg_a),
    .ctrl_len(len_a), .Ack_in(ack_a), .send_ready(rdy_a), .msg_done(done_a),
    .timeout_err(err_a), .Request_out(rq_a), .inter_data_out(dat_a));

  send_msg_param #(.DATA_W(8), .NUM_FIELDS(4), .SYNC_STAGES(3), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .interboard_rst(ibr_b), .ctrl_en(en_b), .ctrl_msg(msg_b),
    .ctrl_len(len_b), .Ack_in(ack_b), .send_ready(rdy_b), .msg_done(done_b),
    .timeout_err(err_b), .Request_out(rq_b), .inter_data_out(dat_b));

  always #5 clk = ~clk;

  task automatic chk_eq(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard: every Request rise must carry the next expected field, data held while Request is high
  task automatic mon(input int k, input logic req, rdy, done, err, input logic [7:0] d);
    if (!rst_n) begin
      preq[k] = 0;
      return;
    end
    if (done || err) chk_eq("done_err_exclusive", done & err, 0);
    if (req) chk_eq("req_not_ready", rdy, 0);
    if (req && !preq[k]) begin
      chk_eq("req_expected", head[k] < tail[k], 1);
      if (head[k] < tail[k]) begin
        chk_eq("field_data", d, expv[k][head[k]]);
        head[k]++;
      end
      held[k] = d;
      hs[k]++;
    end else if (req) chk_eq("data_stable", d, held[k]);
    if (done) begin
      chk_eq("done_expected", pend[k] && head[k] == tail[k], 1);
      chk_eq("done_ready", rdy, 1);
      pend[k] = 0;
      dones[k]++;
    end
    if (err) begin
      chk_eq("err_expected", err_ok[k], 1);
      errs[k]++;
    end
    preq[k] = req;
  endtask

  always @(negedge clk) begin
    mon(0, rq_a, rdy_a, done_a, err_a, {2'b0, dat_a});
    mon(1, rq_b, rdy_b, done_b, err_b, dat_b);
  end

  // responders: raise Ack a fixed delay after Request is seen, drop it once Request falls
  always @(negedge clk) begin
    if (!rst_n || !rq_a) begin ack_a = 0; dc_a = 0; end
    else if (!ack_a) begin if (dc_a >= 2) ack_a = 1; else dc_a++; end
  end
  always @(negedge clk) begin
    if (!rst_n || !rq_b || stuck_b) begin ack_b = 0; dc_b = 0; end
    else ack_b = 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [35:0] m, input int ln);
    int nf = k ? 4 : 6;
    int w = k ? 8 : 6;
    int n = (ln == 0 || ln > nf) ? nf : ln;
    head[k] = 0;
    tail[k] = 0;
    for (int i = 0; i < n; i++) begin
      expv[k][tail[k]] = 8'((m >> (i * w)) & (k ? 36'hFF : 36'h3F));
      tail[k]++;
    end
    pend[k] = 1;
    if (k == 0) begin msg_a = m; len_a = 3'(ln); en_a = 1; end
    else begin msg_b = m[31:0]; len_b = 3'(ln); en_b = 1; end
    tick();
    en_a = 0;
    en_b = 0;
  endtask

  task automatic wait_done(input int k);
    for (int i = 0; i < 400 && pend[k]; i++) tick();
    chk_eq("done_in_time", pend[k], 0);
  endtask

  task automatic measure_b(output int n);
    n = 0;
    for (int i = 0; i < 100 && rq_b; i++) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int base, nd, n;
    #200000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nd, n;
    repeat (3) tick();
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      chk_eq("reset_a", {rdy_a, rq_a, done_a, err_a, dat_a}, {4'b1000, 6'h00});
      chk_eq("reset_b", {rdy_b, rq_b, done_b, err_b, dat_b}, {4'b1000, 8'h00});
      tick();
    end
    // full six-field message with latency pinned by literals
    base = hs[0];
    nd = dones[0];
    send(0, {6'h06, 6'h05, 6'h04, 6'h03, 6'h02, 6'h01}, 6);
    chk_eq("accept_ready_low", {rdy_a, rq_a}, 2'b00);
    tick();
    chk_eq("first_req_data", {rq_a, dat_a}, {1'b1, 6'h01});
    wait_done(0);
    repeat (5) tick();
    chk_eq("full_handshakes", hs[0] - base, 6);
    chk_eq("full_done_once", dones[0] - nd, 1);
    // short message; later msg change and busy ctrl_en must have no effect
    base = hs[0];
    send(0, {6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h15, 6'h0A}, 2);
    repeat (3) tick();
    msg_a = {6{6'h2A}};
    len_a = 3'd5;
    en_a = 1;
    tick();
    en_a = 0;
    wait_done(0);
    repeat (30) tick();
    chk_eq("short_handshakes", hs[0] - base, 2);
    chk_eq("short_idle", {rdy_a, rq_a}, 2'b10);
    // interboard_rst during REQ of field 3
    base = hs[0];
    nd = dones[0];
    send(0, {6'h26, 6'h25, 6'h24, 6'h23, 6'h22, 6'h21}, 6);
    for (int i = 0; i < 300 && hs[0] < base + 4; i++) tick();
    chk_eq("ibr_reached_f3", hs[0] - base, 4);
    chk_eq("ibr_in_req", rq_a, 1);
    head[0] = tail[0];
    pend[0] = 0;
    ibr_a = 1;
    en_a = 1;
    tick();
    ibr_a = 0;
    en_a = 0;
    chk_eq("ibr_abort", {rdy_a, rq_a, dat_a}, {2'b10, 6'h3F});
    repeat (5) tick();
    chk_eq("ibr_hold", {rdy_a, rq_a, dat_a}, {2'b10, 6'h3F});
    chk_eq("ibr_no_done", dones[0] - nd, 0);
    send(0, {6'h36, 6'h35, 6'h34, 6'h33, 6'h32, 6'h31}, 6);
    wait_done(0);
    chk_eq("ibr_resend_done", dones[0] - nd, 1);
    // dut_b: len=0 sends all four 8-bit fields, SYNC_STAGES=3 gives 4 cycles in REQ
    base = hs[1];
    nd = dones[1];
    send(1, {4'h0, 8'hD4, 8'hC3, 8'hB2, 8'hA1}, 0);
    tick();
    chk_eq("b_first_req_data", {rq_b, dat_b}, {1'b1, 8'hA1});
    measure_b(n);
    chk_eq("b_req_cycles", n, 4);
    wait_done(1);
    repeat (5) tick();
    chk_eq("b_handshakes", hs[1] - base, 4);
    chk_eq("b_done_once", dones[1] - nd, 1);
    // dut_b timeout with Ack stuck low
    stuck_b = 1;
    err_ok[1] = 1;
    send(1, 36'h5A, 1);
    tick();
    chk_eq("to_req_data", {rq_b, dat_b}, {1'b1, 8'h5A});
    measure_b(n);
    chk_eq("to_req_cycles", n, 16);
    chk_eq("to_pulse", {err_b, done_b, rdy_b, dat_b}, {3'b101, 8'h5A});
    tick();
    chk_eq("to_single_pulse", {err_b, rdy_b}, 2'b01);
    chk_eq("to_err_count", errs[1], 1);
    pend[1] = 0;
    err_ok[1] = 0;
    stuck_b = 0;
    // rst_n mid-transfer returns to reset values immediately
    send(0, {6'h16, 6'h15, 6'h14, 6'h13, 6'h12, 6'h11}, 6);
    repeat (4) tick();
    rst_n = 0;
    #1;
    chk_eq("async_reset", {rdy_a, rq_a, done_a, err_a, dat_a}, {4'b1000, 6'h00});
    pend[0] = 0;
    head[0] = tail[0];
    tick();
    rst_n = 1;
    repeat (3) tick();
    chk_eq("post_reset_idle", {rdy_a, rq_a, dat_a}, {2'b10, 6'h00});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
